relu_wb_scheduler: RTL and testbench

- Layer-level sequencer for the ReLU/guard write-back unit. Accepts one layer job (tile count, pace, bit mode, buffer base addresses) and issues one ctrl handshake per psum tile to the write-back unit.
- Waits for each tile's finish pulse, then releases the psum tile upstream. Generates feature-map and guard write addresses from the write-back unit's valid/ready strobes, and pulses layer_done after the last tile.

---
 rtl/diff_core_pkg.sv | 20 ++
 rtl/relu_wb_scheduler_if.sv | 37 +++
 rtl/relu_wb_scheduler_wb_addr_gen.sv | 31 +++
 rtl/relu_wb_scheduler.sv | 156 +++++++++++++++
 tb/tb_relu_wb_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_core_pkg.sv
// Shared definitions for the ReLU/guard write-back scheduler slice.
// Holds the scheduler state type, default buffer depths and the derived
// address widths used by the interface, the top and the address counters.
package diff_core_pkg;

  localparam int FM_BUF_DEPTH    = 4096;
  localparam int GUARD_BUF_DEPTH = 1024;
  localparam int FM_ADDR_W       = $clog2(FM_BUF_DEPTH);
  localparam int GUARD_ADDR_W    = $clog2(GUARD_BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TILE,
    ISSUE,
    RUN,
    RELEASE,
    DONE
  } wbs_state_t;

endpackage

// File: rtl/relu_wb_scheduler_if.sv
// Bundle between the scheduler and the write-back unit / output buffers.
//   master (scheduler): drives wb_ctrl_valid, wb_pace, wb_bit_mode,
//                       fm_wr_addr, guard_wr_addr; observes the ctrl
//                       ready/finish and the data/guard valid-ready strobes.
//   slave  (write-back side): the reverse.
interface relu_wb_scheduler_if
  import diff_core_pkg::*;
#(
  parameter int FM_W    = FM_ADDR_W,
  parameter int GUARD_W = GUARD_ADDR_W
);

  logic               wb_ctrl_valid;
  logic               wb_ctrl_ready;
  logic               wb_ctrl_finish;
  logic [15:0]        wb_pace;
  logic               wb_bit_mode;
  logic               wb_data_valid;
  logic               fm_buf_ready;
  logic               wb_guard_valid;
  logic               guard_buf_ready;
  logic [FM_W-1:0]    fm_wr_addr;
  logic [GUARD_W-1:0] guard_wr_addr;

  modport master (
    output wb_ctrl_valid, wb_pace, wb_bit_mode, fm_wr_addr, guard_wr_addr,
    input  wb_ctrl_ready, wb_ctrl_finish, wb_data_valid, fm_buf_ready,
           wb_guard_valid, guard_buf_ready
  );

  modport slave (
    input  wb_ctrl_valid, wb_pace, wb_bit_mode, fm_wr_addr, guard_wr_addr,
    output wb_ctrl_ready, wb_ctrl_finish, wb_data_valid, fm_buf_ready,
           wb_guard_valid, guard_buf_ready
  );

endinterface

// File: rtl/relu_wb_scheduler_wb_addr_gen.sv
// Loadable wrap-around write-address counter.
//   clk, rst_n : clock, asynchronous active-low reset (addr -> 0)
//   load, base : load base (has priority over inc)
//   inc        : advance by one, wrapping to 0 after DEPTH-1
//   addr       : current address
module wb_addr_gen #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  // Explicit compare so non-power-of-two depths wrap correctly.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (inc) begin
      addr <= (addr == LAST) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/relu_wb_scheduler.sv
// Layer-level sequencer for the ReLU/guard write-back unit.
// Accepts one layer job, issues one ctrl handshake per psum tile, waits for
// the tile's finish pulse, releases the psum tile, and pulses layer_done
// after the last tile. Feature-map and guard write addresses advance on the
// write-back strobes and pack contiguously across the tiles of a layer.
//   cfg_*             : layer job (valid/ready handshake)
//   psum_tile_avail   : psum buffer holds a complete tile
//   psum_tile_release : one-cycle pulse per consumed tile
//   tile_cnt          : tiles completed in the current layer
//   layer_done        : one-cycle pulse after the last tile
//   err_timeout       : sticky, set after TIMEOUT_CYCLES in RUN
//   wb                : write-back unit / buffer bundle (master side)
module relu_wb_scheduler
  import diff_core_pkg::*;
#(
  parameter int FM_BUF_DEPTH    = diff_core_pkg::FM_BUF_DEPTH,
  parameter int GUARD_BUF_DEPTH = diff_core_pkg::GUARD_BUF_DEPTH,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [15:0]                        cfg_num_tiles,
  input  logic [15:0]                        cfg_pace,
  input  logic                               cfg_bit_mode,
  input  logic [$clog2(FM_BUF_DEPTH)-1:0]    cfg_fm_base,
  input  logic [$clog2(GUARD_BUF_DEPTH)-1:0] cfg_guard_base,
  input  logic                               psum_tile_avail,
  output logic                               psum_tile_release,
  output logic [15:0]                        tile_cnt,
  output logic                               layer_done,
  output logic                               err_timeout,
  relu_wb_scheduler_if.master                wb
);

  localparam int FM_W      = $clog2(FM_BUF_DEPTH);
  localparam int GUARD_W   = $clog2(GUARD_BUF_DEPTH);
  localparam int RUN_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST  = RUN_CNT_W'(TIMEOUT_CYCLES - 1);

  wbs_state_t           state, state_nx;
  logic [15:0]          num_tiles;
  logic [15:0]          pace;
  logic                 bit_mode;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 accept;
  logic                 busy;
  logic                 ctrl_valid;
  logic [16:0]          tile_next;
  logic [FM_W-1:0]      fm_addr;
  logic [GUARD_W-1:0]   guard_addr;

  assign accept    = cfg_valid && (state == IDLE);
  assign busy      = (state != IDLE);
  assign tile_next = {1'b0, tile_cnt} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    cfg_ready         = 1'b0;
    ctrl_valid        = 1'b0;
    psum_tile_release = 1'b0;
    layer_done        = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nx = (cfg_num_tiles == '0) ? DONE : WAIT_TILE;
      end
      WAIT_TILE: begin
        if (psum_tile_avail) state_nx = ISSUE;
      end
      ISSUE: begin
        // Finish is deliberately not looked at here, so a stale pulse from
        // the previous tile cannot complete this one.
        ctrl_valid = 1'b1;
        if (wb.wb_ctrl_ready) state_nx = RUN;
      end
      RUN: begin
        if (wb.wb_ctrl_finish) state_nx = RELEASE;
      end
      RELEASE: begin
        psum_tile_release = 1'b1;
        state_nx = (tile_next == {1'b0, num_tiles}) ? DONE : WAIT_TILE;
      end
      DONE: begin
        layer_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job registers, tile counter and RUN watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_tiles   <= '0;
      pace        <= '0;
      bit_mode    <= 1'b0;
      tile_cnt    <= '0;
      run_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        num_tiles <= cfg_num_tiles;
        pace      <= cfg_pace;
        bit_mode  <= cfg_bit_mode;
        tile_cnt  <= '0;
      end else if (state == RELEASE && tile_cnt != 16'hFFFF) begin
        tile_cnt <= tile_cnt + 16'd1;
      end

      // Counter is held at 0 outside RUN, so it starts from 0 on RUN entry.
      if (state != RUN) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_LIMIT) begin
        run_cnt <= run_cnt + RUN_CNT_W'(1);
      end

      if (state == RUN && run_cnt == RUN_LAST) err_timeout <= 1'b1;
    end
  end

  wb_addr_gen #(.DEPTH(FM_BUF_DEPTH), .ADDR_W(FM_W)) u_fm_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .base (cfg_fm_base),
    .inc  (busy && wb.wb_data_valid && wb.fm_buf_ready),
    .addr (fm_addr)
  );

  wb_addr_gen #(.DEPTH(GUARD_BUF_DEPTH), .ADDR_W(GUARD_W)) u_guard_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .base (cfg_guard_base),
    .inc  (busy && wb.wb_guard_valid && wb.guard_buf_ready),
    .addr (guard_addr)
  );

  assign wb.wb_ctrl_valid = ctrl_valid;
  assign wb.wb_pace       = pace;
  assign wb.wb_bit_mode   = bit_mode;
  assign wb.fm_wr_addr    = fm_addr;
  assign wb.guard_wr_addr = guard_addr;

endmodule

// File: tb/tb_relu_wb_scheduler.sv
// Scoreboard bench for relu_wb_scheduler: directed jobs push expected
// handshake / release / layer_done events; a negedge monitor pops and
// compares them as the DUT presents them.
module tb_relu_wb_scheduler;
  import diff_core_pkg::*;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_num_tiles = '0;
  logic [15:0] cfg_pace = '0;
  logic        cfg_bit_mode = 1'b0;
  logic [FM_ADDR_W-1:0]    cfg_fm_base = '0;
  logic [GUARD_ADDR_W-1:0] cfg_guard_base = '0;
  logic        psum_tile_avail = 1'b1;
  logic        psum_tile_release;
  logic [15:0] tile_cnt;
  logic        layer_done;
  logic        err_timeout;

  relu_wb_scheduler_if wb ();

  relu_wb_scheduler #(
    .FM_BUF_DEPTH(FM_BUF_DEPTH), .GUARD_BUF_DEPTH(GUARD_BUF_DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_tiles(cfg_num_tiles), .cfg_pace(cfg_pace), .cfg_bit_mode(cfg_bit_mode),
    .cfg_fm_base(cfg_fm_base), .cfg_guard_base(cfg_guard_base),
    .psum_tile_avail(psum_tile_avail), .psum_tile_release(psum_tile_release),
    .tile_cnt(tile_cnt), .layer_done(layer_done), .err_timeout(err_timeout), .wb(wb)
  );

  always #5 clk = ~clk;

  typedef enum {EV_HS, EV_REL, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int pace;
    int bm;
    int tcnt;
    int fm;
    int guard;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input int pace, bm, tcnt, fm, guard);
    ev_t e;
    e.kind = k; e.pace = pace; e.bm = bm; e.tcnt = tcnt; e.fm = fm; e.guard = guard;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: actual=%s required=none @%0t", k.name(), $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        failures++;
        $display("FAIL event_order: actual=%s required=%s @%0t", k.name(), e.kind.name(), $time);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compares each presented event against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (rst_n) begin
      if (wb.wb_ctrl_valid && wb.wb_ctrl_ready) begin
        take(EV_HS, e, ok);
        if (ok) begin
          check("hs_pace", 32'(wb.wb_pace), e.pace);
          check("hs_bit_mode", 32'(wb.wb_bit_mode), e.bm);
        end
      end
      if (psum_tile_release) begin
        take(EV_REL, e, ok);
        if (ok) check("rel_tile_cnt", 32'(tile_cnt), e.tcnt);
      end
      if (layer_done) begin
        take(EV_DONE, e, ok);
        if (ok) begin
          check("done_tile_cnt", 32'(tile_cnt), e.tcnt);
          check("done_fm_addr", 32'(wb.fm_wr_addr), e.fm);
          check("done_guard_addr", 32'(wb.guard_wr_addr), e.guard);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_ctrl_valid", 32'(wb.wb_ctrl_valid), 0);
    check("rst_pace", 32'(wb.wb_pace), 0);
    check("rst_bit_mode", 32'(wb.wb_bit_mode), 0);
    check("rst_release", 32'(psum_tile_release), 0);
    check("rst_layer_done", 32'(layer_done), 0);
    check("rst_tile_cnt", 32'(tile_cnt), 0);
    check("rst_fm_addr", 32'(wb.fm_wr_addr), 0);
    check("rst_guard_addr", 32'(wb.guard_wr_addr), 0);
    check("rst_err", 32'(err_timeout), 0);
  endtask

  task automatic start_job(input int n, pace, bm, fmb, gb);
    cfg_num_tiles  = 16'(n);
    cfg_pace       = 16'(pace);
    cfg_bit_mode   = 1'(bm);
    cfg_fm_base    = FM_ADDR_W'(fmb);
    cfg_guard_base = GUARD_ADDR_W'(gb);
    check("cfg_ready_idle", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("cfg_ready_busy", 32'(cfg_ready), 0);
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (!wb.wb_ctrl_valid && i < budget) begin
      step();
      i++;
    end
    check("ctrl_valid_seen", 32'(wb.wb_ctrl_valid), 1);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!layer_done && i < budget) begin
      check("no_valid_to_done", 32'(wb.wb_ctrl_valid), 0);
      step();
      i++;
    end
    check("layer_done_seen", 32'(layer_done), 1);
    step();
    check("layer_done_pulse", 32'(layer_done), 0);
    check("cfg_ready_back", 32'(cfg_ready), 1);
  endtask

  // Handshake one tile, drive strobes in RUN, then finish; returns in RELEASE.
  task automatic do_tile(input int ndata, nguard, rdy_delay, input bit early_fin, input int pace);
    int n;
    wait_valid(20);
    for (int i = 0; i < rdy_delay; i++) begin
      wb.wb_ctrl_finish = early_fin && (i == 0);
      step();
      check("issue_valid_hold", 32'(wb.wb_ctrl_valid), 1);
      check("issue_pace_stable", 32'(wb.wb_pace), pace);
    end
    wb.wb_ctrl_finish = early_fin;
    wb.wb_ctrl_ready  = 1'b1;
    step();
    wb.wb_ctrl_ready  = 1'b0;
    wb.wb_ctrl_finish = 1'b0;
    check("valid_drop", 32'(wb.wb_ctrl_valid), 0);
    n = (ndata > nguard) ? ndata : nguard;
    for (int i = 0; i < n; i++) begin
      wb.wb_data_valid   = (i < ndata);
      wb.fm_buf_ready    = 1'b1;
      wb.wb_guard_valid  = (i < nguard);
      wb.guard_buf_ready = 1'b1;
      step();
    end
    wb.wb_data_valid  = 1'b0;
    wb.wb_guard_valid = 1'b0;
    step();
    check("no_early_release", 32'(psum_tile_release), 0);
    check("run_pace_stable", 32'(wb.wb_pace), pace);
    wb.wb_ctrl_finish = 1'b1;
    step();
    wb.wb_ctrl_finish = 1'b0;
    check("release_latency", 32'(psum_tile_release), 1);
  endtask

  initial begin
    int exp_fm;
    wb.wb_ctrl_ready = 1'b0; wb.wb_ctrl_finish = 1'b0;
    wb.wb_data_valid = 1'b0; wb.fm_buf_ready = 1'b0;
    wb.wb_guard_valid = 1'b0; wb.guard_buf_ready = 1'b0;
    #12;
    check_reset_vals();
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Single tile, pace 3, fm_base 10: 5 data strobes, 1 guard strobe.
    push(EV_HS, 3, 0, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0); push(EV_DONE, 0, 0, 1, 15, 1);
    start_job(1, 3, 0, 10, 0);
    check("lat_wait_tile", 32'(wb.wb_ctrl_valid), 0);
    step();
    check("lat_issue", 32'(wb.wb_ctrl_valid), 1);
    do_tile(5, 1, 0, 0, 3);
    wait_done(3);

    // Three tiles, psum not available for 4 cycles before tile 2.
    push(EV_HS, 7, 1, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0);
    push(EV_HS, 7, 1, 0, 0, 0); push(EV_REL, 0, 0, 1, 0, 0);
    push(EV_HS, 7, 1, 0, 0, 0); push(EV_REL, 0, 0, 2, 0, 0);
    push(EV_DONE, 0, 0, 3, 106, 53);
    start_job(3, 7, 1, 100, 50);
    do_tile(2, 1, 0, 0, 7);
    psum_tile_avail = 1'b0;
    repeat (4) begin
      step();
      check("gap_no_valid", 32'(wb.wb_ctrl_valid), 0);
    end
    psum_tile_avail = 1'b1;
    do_tile(3, 2, 0, 0, 7);
    do_tile(1, 0, 0, 0, 7);
    wait_done(3);
    check("tile_cnt_final", 32'(tile_cnt), 3);

    // Zero-tile layer: no ctrl request, straight to layer_done.
    push(EV_DONE, 0, 0, 0, 7, 3);
    start_job(0, 4, 0, 7, 3);
    wait_done(2);

    // Address wrap with fm_buf_ready toggling; guard wraps too.
    push(EV_HS, 5, 0, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0); push(EV_DONE, 0, 0, 1, 2, 0);
    start_job(1, 5, 0, 4094, 1023);
    wait_valid(20);
    wb.wb_ctrl_ready = 1'b1;
    step();
    wb.wb_ctrl_ready = 1'b0;
    exp_fm = 4094;
    for (int i = 0; i < 8; i++) begin
      wb.wb_data_valid   = 1'b1;
      wb.fm_buf_ready    = (i % 2 == 0);
      wb.wb_guard_valid  = (i == 0);
      wb.guard_buf_ready = 1'b1;
      if (i % 2 == 0) exp_fm = (exp_fm == 4095) ? 0 : exp_fm + 1;
      step();
      check("wrap_fm_addr", 32'(wb.fm_wr_addr), exp_fm);
    end
    wb.wb_data_valid = 1'b0; wb.wb_guard_valid = 1'b0;
    check("wrap_guard_addr", 32'(wb.guard_wr_addr), 0);
    wb.wb_ctrl_finish = 1'b1;
    step();
    wb.wb_ctrl_finish = 1'b0;
    check("wrap_release", 32'(psum_tile_release), 1);
    wait_done(3);

    // Strobes while idle leave the addresses alone.
    wb.wb_data_valid = 1'b1; wb.fm_buf_ready = 1'b1;
    wb.wb_guard_valid = 1'b1; wb.guard_buf_ready = 1'b1;
    step(); step();
    wb.wb_data_valid = 1'b0; wb.wb_guard_valid = 1'b0;
    check("idle_strobe_fm", 32'(wb.fm_wr_addr), 2);
    check("idle_strobe_guard", 32'(wb.guard_wr_addr), 0);

    // Ready held low, early finishes ignored, then RUN timeout.
    push(EV_HS, 'h1234, 1, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0); push(EV_DONE, 0, 0, 1, 20, 30);
    start_job(1, 'h1234, 1, 20, 30);
    wait_valid(20);
    for (int i = 0; i < 6; i++) begin
      wb.wb_ctrl_finish = (i == 0);
      step();
      check("stall_valid_hold", 32'(wb.wb_ctrl_valid), 1);
      check("stall_pace", 32'(wb.wb_pace), 'h1234);
    end
    wb.wb_ctrl_ready = 1'b1; wb.wb_ctrl_finish = 1'b1;
    step();
    wb.wb_ctrl_ready = 1'b0; wb.wb_ctrl_finish = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1)  check("accept_finish_ignored", 32'(psum_tile_release), 0);
      if (k == 19) check("err_before_limit", 32'(err_timeout), 0);
      if (k == 20) check("err_at_limit", 32'(err_timeout), 1);
      if (k == 25) check("err_held_in_run", 32'(err_timeout), 1);
    end
    check("timeout_stays_run", 32'(psum_tile_release), 0);
    wb.wb_ctrl_finish = 1'b1;
    step();
    wb.wb_ctrl_finish = 1'b0;
    check("late_release", 32'(psum_tile_release), 1);
    wait_done(3);
    check("err_sticky", 32'(err_timeout), 1);

    // Reset in the middle of tile 2's RUN, then a clean job.
    push(EV_HS, 9, 0, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0); push(EV_HS, 9, 0, 0, 0, 0);
    start_job(3, 9, 0, 200, 40);
    do_tile(2, 1, 0, 0, 9);
    wait_valid(20);
    wb.wb_ctrl_ready = 1'b1;
    step();
    wb.wb_ctrl_ready = 1'b0;
    wb.wb_data_valid = 1'b1; wb.fm_buf_ready = 1'b1;
    step();
    wb.wb_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    push(EV_HS, 2, 1, 0, 0, 0); push(EV_REL, 0, 0, 0, 0, 0); push(EV_DONE, 0, 0, 1, 3, 2);
    start_job(1, 2, 1, 0, 0);
    do_tile(3, 2, 1, 0, 2);
    wait_done(3);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
